// File: rtl/seg_scan_display.sv
// Multiplexed N-digit 7-segment hex display driver.
// Holds a VALUE_W-bit word, scans its top DIGITS nibbles onto a shared segment
// bus, and can periodically rotate the held word left or right by whole nibbles.
// All outputs are registered so that segments and digit select switch together.
module seg_scan_display #(
    parameter int DIGITS      = 2,
    parameter int VALUE_W     = 32,
    parameter int SCAN_DIV    = 1024,
    parameter int ROT_DIV     = 33554432,
    parameter int ROT_STEP    = 2,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [VALUE_W-1:0] value_i,
    input  logic               rot_en_i,
    input  logic               rot_dir_i,
    input  logic [DIGITS-1:0]  blank_i,
    output logic [6:0]         seg_o,
    output logic [DIGITS-1:0]  dig_sel_o,
    output logic               frame_o,
    output logic               rot_step_o
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int ROT_W  = (ROT_DIV > 2) ? $clog2(ROT_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RS_W   = 4 * ROT_STEP;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROT_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

    // Reject unusable parameter sets at elaboration rather than clamping them.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_display: DIGITS must be 1..8");
    end
    if ((VALUE_W % 4) != 0 || VALUE_W < 4 * DIGITS) begin : g_bad_width
        $error("seg_scan_display: VALUE_W must be a multiple of 4 and >= 4*DIGITS");
    end
    if (ROT_STEP < 1 || ROT_STEP > VALUE_W / 4 - 1) begin : g_bad_step
        $error("seg_scan_display: ROT_STEP must be 1..VALUE_W/4-1");
    end
    if (SCAN_DIV < 2 || ROT_DIV < 2) begin : g_bad_div
        $error("seg_scan_display: SCAN_DIV and ROT_DIV must be >= 2");
    end
    if (SEG_ACT_LOW != 0 && SEG_ACT_LOW != 1) begin : g_bad_pol
        $error("seg_scan_display: SEG_ACT_LOW must be 0 or 1");
    end

    logic [VALUE_W-1:0] value_reg;
    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [ROT_W-1:0]   rot_cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [6:0]         seg_reg;
    logic [DIGITS-1:0]  dig_sel_reg;
    logic               frame_reg;
    logic               rot_step_reg;

    logic               scan_last;
    logic               idx_last;
    logic               rot_hit;
    logic [3:0]         nib_arr [DIGITS];
    logic [DIGITS-1:0]  dig_sel_next;
    logic [6:0]         pattern;
    logic [6:0]         seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0111111;
            4'h1: hex7 = 7'b0000110;
            4'h2: hex7 = 7'b1011011;
            4'h3: hex7 = 7'b1001111;
            4'h4: hex7 = 7'b1100110;
            4'h5: hex7 = 7'b1101101;
            4'h6: hex7 = 7'b1111101;
            4'h7: hex7 = 7'b0000111;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1101111;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b1111100;
            4'hC: hex7 = 7'b0111001;
            4'hD: hex7 = 7'b1011110;
            4'hE: hex7 = 7'b1111001;
            default: hex7 = 7'b1110001;
        endcase
    endfunction

    assign scan_last = (scan_cnt_reg == SCAN_LAST);
    assign idx_last  = (idx_reg == IDX_LAST);
    assign rot_hit   = rot_en_i && (rot_cnt_reg == ROT_LAST);

    // Digit 0 is the most-significant nibble of the held word.
    genvar gi;
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign nib_arr[gi]      = value_reg[VALUE_W-1-4*gi -: 4];
        assign dig_sel_next[gi] = (idx_reg == IDX_W'(gi));
    end

    // Decode the currently scanned nibble, apply blanking, then polarity.
    always_comb begin
        pattern  = 7'b0000000;
        if (!blank_i[idx_reg]) begin
            pattern = hex7(nib_arr[idx_reg]);
        end
        seg_next = (SEG_ACT_LOW != 0) ? ~pattern : pattern;
    end

    // Scan timer: dwell SCAN_DIV cycles per digit, then advance the index.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
        end else if (scan_last) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_last ? '0 : idx_reg + IDX_W'(1);
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
        end
    end

    // Held word: load has priority over a rotation landing on the same edge.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            value_reg   <= '0;
            rot_cnt_reg <= '0;
        end else if (load_i) begin
            value_reg   <= value_i;
            rot_cnt_reg <= '0;
        end else if (!rot_en_i) begin
            rot_cnt_reg <= '0;
        end else if (rot_hit) begin
            rot_cnt_reg <= '0;
            if (rot_dir_i) begin
                value_reg <= {value_reg[RS_W-1:0], value_reg[VALUE_W-1:RS_W]};
            end else begin
                value_reg <= {value_reg[VALUE_W-RS_W-1:0], value_reg[VALUE_W-1 -: RS_W]};
            end
        end else begin
            rot_cnt_reg <= rot_cnt_reg + ROT_W'(1);
        end
    end

    // Output registers: segments and select both derive from the same idx sample.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            seg_reg      <= SEG_OFF;
            dig_sel_reg  <= '0;
            frame_reg    <= 1'b0;
            rot_step_reg <= 1'b0;
        end else begin
            seg_reg      <= seg_next;
            dig_sel_reg  <= dig_sel_next;
            frame_reg    <= scan_last && idx_last;
            rot_step_reg <= rot_hit && !load_i;
        end
    end

    assign seg_o      = seg_reg;
    assign dig_sel_o  = dig_sel_reg;
    assign frame_o    = frame_reg;
    assign rot_step_o = rot_step_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (2 digits, 32-bit value, scan 4, rotate 8, step 2, active-low).
// A behavioural model pushes the expected registered outputs each clock edge; a
// monitor pops and compares them half a cycle later. Directed checks cover the
// named display patterns, pulse periods, load-versus-rotate priority and reset.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        load_i = 1'b0;
    logic [31:0] value_i = '0;
    logic        rot_en_i = 1'b0;
    logic        rot_dir_i = 1'b0;
    logic [1:0]  blank_i = '0;
    logic [6:0]  seg_o;
    logic [1:0]  dig_sel_o;
    logic        frame_o;
    logic        rot_step_o;

    int n_run  = 0;
    int n_fail = 0;

    // Active-high gfedcba patterns for hex digits 0..F.
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [1:0] sel;
        logic [6:0] seg;
        logic       frame;
        logic       step;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] m_val  = '0;
    int          m_scan = 0;
    int          m_rot  = 0;
    int          m_idx  = 0;

    seg_scan_display #(
        .DIGITS(2), .VALUE_W(32), .SCAN_DIV(4), .ROT_DIV(8), .ROT_STEP(2), .SEG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_i(rst_i), .load_i(load_i), .value_i(value_i),
        .rot_en_i(rot_en_i), .rot_dir_i(rot_dir_i), .blank_i(blank_i),
        .seg_o(seg_o), .dig_sel_o(dig_sel_o), .frame_o(frame_o), .rot_step_o(rot_step_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: expected outputs for each edge, pushed when the edge occurs.
    initial begin : model
        exp_t       e;
        logic [3:0] nib;
        logic [6:0] pat;
        forever begin
            @(posedge clk or negedge rst_i);
            if (!rst_i) begin
                m_val = '0; m_scan = 0; m_rot = 0; m_idx = 0;
                if (clk) begin
                    e.sel = 2'b00; e.seg = 7'h7F; e.frame = 1'b0; e.step = 1'b0;
                    sb_q.push_back(e);
                end
            end else begin
                nib     = 4'(m_val >> (28 - 4 * m_idx));
                pat     = blank_i[m_idx] ? 7'h00 : seg_tab[nib];
                e.sel   = 2'(1 << m_idx);
                e.seg   = ~pat;
                e.frame = (m_scan == 3) && (m_idx == 1);
                e.step  = rot_en_i && (m_rot == 7) && !load_i;
                sb_q.push_back(e);
                if (load_i) begin
                    m_val = value_i; m_rot = 0;
                end else if (rot_en_i) begin
                    if (m_rot == 7) begin
                        m_rot = 0;
                        m_val = rot_dir_i ? {m_val[7:0], m_val[31:8]} : {m_val[23:0], m_val[31:24]};
                    end else begin
                        m_rot++;
                    end
                end else begin
                    m_rot = 0;
                end
                if (m_scan == 3) begin
                    m_scan = 0; m_idx = (m_idx + 1) % 2;
                end else begin
                    m_scan++;
                end
            end
        end
    end

    // Monitor: compare DUT outputs against the model away from the active edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_sel",   32'(dig_sel_o),  32'(e.sel));
                check("sb_seg",   32'(seg_o),      32'(e.seg));
                check("sb_frame", 32'(frame_o),    32'(e.frame));
                check("sb_step",  32'(rot_step_o), 32'(e.step));
            end
        end
    end

    task automatic load_val(input logic [31:0] v);
        load_i  = 1'b1;
        value_i = v;
        @(negedge clk);
        load_i  = 1'b0;
        $display("[TB] load %08h", v);
    endtask

    // Count negedges until frame_o (which=0) or rot_step_o (which=1) is seen high.
    task automatic wait_pulse(input bit which, input string tag, output int cyc);
        logic p;
        p   = 1'b0;
        cyc = 0;
        for (int i = 0; i < 64 && !p; i++) begin
            @(negedge clk);
            cyc++;
            p = which ? rot_step_o : frame_o;
        end
        if (!p) check({tag, "_timeout"}, 32'(p), 32'd1);
    endtask

    // Wait for digit k to be selected, then compare its segments with ~pat.
    task automatic show_digit(input int k, input logic [6:0] pat, input string tag);
        logic [6:0] want;
        logic       seen;
        want = ~pat;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dig_sel_o == 2'(1 << k)) begin
                seen = 1'b1;
                check(tag, 32'(seg_o), 32'(want));
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'(dig_sel_o), 32'(1 << k));
        $display("[TB] digit %0d %s", k, tag);
    endtask

    // Spend exactly ncyc negedges, checking digit k's segments the first time it is shown.
    task automatic watch_digit(input int k, input logic [6:0] pat, input int ncyc, input string tag);
        logic [6:0] want;
        logic       seen;
        want = ~pat;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!seen && dig_sel_o == 2'(1 << k)) begin
                seen = 1'b1;
                check(tag, 32'(seg_o), 32'(want));
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'(dig_sel_o), 32'(1 << k));
        $display("[TB] watch %s", tag);
    endtask

    initial begin : stim
        int         c;
        logic [6:0] step_pats [4];
        step_pats = '{7'h06, 7'h77, 7'h79, 7'h3F};   // digit 1 after each left step: 1, A, E, 0

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(dig_sel_o), 32'd0);
        check("rst_seg", 32'(seg_o), 32'h7F);
        rst_i = 1'b1;

        // Scan and decode of a loaded value.
        load_val(32'hC001CAFE);
        @(negedge clk);
        show_digit(0, 7'h39, "scan_C");
        show_digit(1, 7'h3F, "scan_0");
        wait_pulse(1'b0, "frame", c);
        wait_pulse(1'b0, "frame", c);
        check("frame_period", 32'(c), 32'd8);

        // Left rotation sequence.
        rot_en_i = 1'b1;
        wait_pulse(1'b1, "rot", c);
        check("rot_first", 32'(c), 32'd8);
        for (int s = 0; s < 4; s++) begin
            watch_digit(1, step_pats[s], 7, $sformatf("rotl_%0d", s));
            if (s < 3) begin
                wait_pulse(1'b1, "rot", c);
                check("rot_period", 32'(c), 32'd1);
            end
        end

        // Right step, then a load landing exactly on the rotation terminal.
        rot_dir_i = 1'b1;
        wait_pulse(1'b1, "rotr", c);
        check("rotr_period", 32'(c), 32'd1);
        watch_digit(1, 7'h79, 7, "rotr_E");
        load_val(32'h12345678);
        check("load_no_step", 32'(rot_step_o), 32'd0);
        wait_pulse(1'b1, "rot_after_load", c);
        check("rot_after_load", 32'(c), 32'd8);
        watch_digit(0, 7'h07, 7, "rotr_7");
        rot_en_i  = 1'b0;
        rot_dir_i = 1'b0;

        // Blanking: digit 1 blanked, digit 0 shows '8'.
        blank_i = 2'b10;
        load_val(32'h88123456);
        @(negedge clk);
        show_digit(0, 7'h7F, "blank_d0");
        show_digit(1, 7'h00, "blank_d1");
        blank_i = 2'b00;

        // Every nibble through digit 0.
        for (int n = 0; n < 16; n++) begin
            load_val({4'(n), 28'h0});
            @(negedge clk);
            show_digit(0, seg_tab[n], $sformatf("nib_%0h", n));
        end

        // Asynchronous reset in the middle of digit 1's dwell.
        c = 0;
        while (dig_sel_o != 2'b10 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("mid_scan_sel", 32'(dig_sel_o), 32'd2);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_sel", 32'(dig_sel_o), 32'd0);
        check("async_rst_seg", 32'(seg_o), 32'h7F);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("post_rst_sel", 32'(dig_sel_o), 32'd1);
        check("post_rst_seg", 32'(seg_o), 32'h40);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
